// File: rtl/sdram_port_scheduler_pkg.sv
// Shared types and helpers for the SDRAM port scheduler.
package sdram_port_scheduler_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_BUSY, ST_UPDATE} state_t;

  localparam int PORT_W = 2;
  localparam int IDX_W  = 3;

  // Distance from the round-robin pointer to candidate j, walking upward with wrap.
  function automatic int rr_dist(input int j, input int ptr, input int n);
    return (j - ptr + n) % n;
  endfunction
endpackage

// File: rtl/sdram_port_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the requester nearest at/after the pointer.
module sdram_port_scheduler_rr_arbiter
  import sdram_port_scheduler_pkg::*;
#(
  parameter int N = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx
);
  logic [IDX_W-1:0] ptr;
  int               best;

  always_comb begin
    best = N;
    idx  = '0;
    for (int j = 0; j < N; j++) begin
      if (req[j] && rr_dist(j, int'(ptr), N) < best) begin
        best = rr_dist(j, int'(ptr), N);
        idx  = IDX_W'(j);
      end
    end
    grant = '0;
    for (int j = 0; j < N; j++) grant[j] = (best < N) && (int'(idx) == j);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          ptr <= '0;
    else if (advance) ptr <= (int'(idx) == N - 1) ? '0 : idx + 1'b1;
  end
endmodule

// File: rtl/sdram_port_scheduler.sv
// Multi-port SDRAM burst scheduler: picks an eligible FIFO port, issues one burst, tracks per-port pointers.
module sdram_port_scheduler
  import sdram_port_scheduler_pkg::*;
#(
  parameter int NUM_WR   = 2,
  parameter int NUM_RD   = 2,
  parameter int ASIZE    = 23,
  parameter int LSIZE    = 9,
  parameter int USIZE    = 16,
  parameter int RD_FIRST = 1
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [NUM_WR*ASIZE-1:0] WR_START,
  input  logic [NUM_WR*ASIZE-1:0] WR_MAX,
  input  logic [NUM_WR*LSIZE-1:0] WR_LEN,
  input  logic [NUM_WR-1:0]       WR_LOAD,
  input  logic [NUM_WR*USIZE-1:0] WR_USED,
  input  logic [NUM_RD*ASIZE-1:0] RD_START,
  input  logic [NUM_RD*ASIZE-1:0] RD_MAX,
  input  logic [NUM_RD*LSIZE-1:0] RD_LEN,
  input  logic [NUM_RD-1:0]       RD_LOAD,
  input  logic [NUM_RD*USIZE-1:0] RD_USED,
  output logic                    REQ,
  output logic                    REQ_WR,
  output logic [ASIZE-1:0]        REQ_ADDR,
  output logic [LSIZE-1:0]        REQ_LEN,
  output logic [PORT_W-1:0]       REQ_PORT,
  input  logic                    ACK,
  input  logic                    DONE,
  output logic [NUM_WR-1:0]       WR_MASK,
  output logic [NUM_RD-1:0]       RD_MASK
);
  state_t              state;
  logic                idle, ld_hit, ld_now, win_any, win_wr;
  logic [PORT_W-1:0]   win_port;
  logic [NUM_RD-1:0]   rd_elig, rd_gnt;
  logic [NUM_WR-1:0]   wr_elig, wr_gnt;
  logic [ASIZE-1:0]    rd_cur [NUM_RD];
  logic [ASIZE-1:0]    wr_cur [NUM_WR];
  logic [ASIZE-1:0]    sel_addr;
  logic [LSIZE-1:0]    sel_len;

  assign idle = (state == ST_IDLE);

  function automatic logic [ASIZE-1:0] next_ptr(input logic [ASIZE-1:0] p, input logic [ASIZE-1:0] s,
                                                input logic [ASIZE-1:0] m, input logic [LSIZE-1:0] l);
    return (p < m - ASIZE'(l)) ? p + ASIZE'(l) : s;
  endfunction

  // Pointers start out tracking START live until first load/update, avoiding a data-dependent async reset.
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ASIZE-1:0] p, start, maxa;
    logic [LSIZE-1:0] len;
    logic             ok, upd;
    assign start      = RD_START[i*ASIZE +: ASIZE];
    assign maxa       = RD_MAX[i*ASIZE +: ASIZE];
    assign len        = RD_LEN[i*LSIZE +: LSIZE];
    assign rd_elig[i] = (32'(RD_USED[i*USIZE +: USIZE]) < 32'(len)) && (len != '0) && !RD_LOAD[i];
    assign rd_cur[i]  = ok ? p : start;
    assign upd        = (state == ST_UPDATE) && !REQ_WR && (int'(REQ_PORT) == i) && !ld_hit;
    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)           begin ok <= 1'b0; p <= '0; end
      else if (RD_LOAD[i]) begin ok <= 1'b1; p <= start; end
      else if (upd)        begin ok <= 1'b1; p <= next_ptr(rd_cur[i], start, maxa, len); end
    end
  end

  for (genvar i = 0; i < NUM_WR; i++) begin : g_wr
    logic [ASIZE-1:0] p, start, maxa;
    logic [LSIZE-1:0] len;
    logic             ok, upd;
    assign start      = WR_START[i*ASIZE +: ASIZE];
    assign maxa       = WR_MAX[i*ASIZE +: ASIZE];
    assign len        = WR_LEN[i*LSIZE +: LSIZE];
    assign wr_elig[i] = (32'(WR_USED[i*USIZE +: USIZE]) >= 32'(len)) && (len != '0) && !WR_LOAD[i];
    assign wr_cur[i]  = ok ? p : start;
    assign upd        = (state == ST_UPDATE) && REQ_WR && (int'(REQ_PORT) == i) && !ld_hit;
    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)           begin ok <= 1'b0; p <= '0; end
      else if (WR_LOAD[i]) begin ok <= 1'b1; p <= start; end
      else if (upd)        begin ok <= 1'b1; p <= next_ptr(wr_cur[i], start, maxa, len); end
    end
  end

  if (RD_FIRST != 0) begin : g_split
    logic [IDX_W-1:0] rd_idx, wr_idx;
    logic [NUM_RD-1:0] rd_g;
    logic [NUM_WR-1:0] wr_g;
    sdram_port_scheduler_rr_arbiter #(.N(NUM_RD)) u_rd_arb (
      .clk(CLK), .rst(RESET), .req(rd_elig), .advance(idle && |rd_elig), .grant(rd_g), .idx(rd_idx));
    sdram_port_scheduler_rr_arbiter #(.N(NUM_WR)) u_wr_arb (
      .clk(CLK), .rst(RESET), .req(wr_elig), .advance(idle && !(|rd_elig) && |wr_elig),
      .grant(wr_g), .idx(wr_idx));
    assign win_any  = |rd_elig || |wr_elig;
    assign win_wr   = !(|rd_elig);
    assign win_port = win_wr ? PORT_W'(wr_idx) : PORT_W'(rd_idx);
    assign rd_gnt   = rd_g;
    assign wr_gnt   = wr_g;
  end else begin : g_joint
    logic [IDX_W-1:0]         idx;
    logic [NUM_RD+NUM_WR-1:0] g;
    sdram_port_scheduler_rr_arbiter #(.N(NUM_RD + NUM_WR)) u_arb (
      .clk(CLK), .rst(RESET), .req({wr_elig, rd_elig}), .advance(idle && win_any), .grant(g), .idx(idx));
    assign win_any  = |{wr_elig, rd_elig};
    assign win_wr   = int'(idx) >= NUM_RD;
    assign win_port = win_wr ? PORT_W'(int'(idx) - NUM_RD) : PORT_W'(idx);
    assign rd_gnt   = g[NUM_RD-1:0];
    assign wr_gnt   = g[NUM_RD+NUM_WR-1:NUM_RD];
  end

  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    ld_now   = 1'b0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (!win_wr && int'(win_port) == k) begin
        sel_addr = rd_cur[k];
        sel_len  = RD_LEN[k*LSIZE +: LSIZE];
      end
      if (!REQ_WR && int'(REQ_PORT) == k && RD_LOAD[k]) ld_now = 1'b1;
    end
    for (int k = 0; k < NUM_WR; k++) begin
      if (win_wr && int'(win_port) == k) begin
        sel_addr = wr_cur[k];
        sel_len  = WR_LEN[k*LSIZE +: LSIZE];
      end
      if (REQ_WR && int'(REQ_PORT) == k && WR_LOAD[k]) ld_now = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= ST_IDLE;
      REQ      <= 1'b0;
      REQ_WR   <= 1'b0;
      REQ_ADDR <= '0;
      REQ_LEN  <= '0;
      REQ_PORT <= '0;
      WR_MASK  <= '0;
      RD_MASK  <= '0;
      ld_hit   <= 1'b0;
    end else begin
      // A reload of the in-flight port anywhere in the burst suppresses its UPDATE step.
      ld_hit <= idle ? 1'b0 : (ld_hit | ld_now);
      unique case (state)
        ST_IDLE: if (win_any) begin
          REQ      <= 1'b1;
          REQ_WR   <= win_wr;
          REQ_ADDR <= sel_addr;
          REQ_LEN  <= sel_len;
          REQ_PORT <= win_port;
          RD_MASK  <= win_wr ? '0 : rd_gnt;
          WR_MASK  <= win_wr ? wr_gnt : '0;
          state    <= ST_ISSUE;
        end
        ST_ISSUE: if (DONE) begin
          REQ     <= 1'b0;
          RD_MASK <= '0;
          WR_MASK <= '0;
          state   <= ST_UPDATE;
        end else if (ACK) begin
          REQ   <= 1'b0;
          state <= ST_BUSY;
        end
        ST_BUSY: if (DONE) begin
          RD_MASK <= '0;
          WR_MASK <= '0;
          state   <= ST_UPDATE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sdram_port_scheduler.sv
// Randomized bench for sdram_port_scheduler against a burst-level reference model.
module tb_sdram_port_scheduler;
  localparam int NW = 2, NR = 2, A = 23, L = 9, U = 16;

  logic clk = 1'b0, rst = 1'b1;
  logic [NW*A-1:0] wr_start_f, wr_max_f;
  logic [NW*L-1:0] wr_len_f;
  logic [NW*U-1:0] wr_used_f;
  logic [NW-1:0]   wr_load_f, wr_mask;
  logic [NR*A-1:0] rd_start_f, rd_max_f;
  logic [NR*L-1:0] rd_len_f;
  logic [NR*U-1:0] rd_used_f;
  logic [NR-1:0]   rd_load_f, rd_mask;
  logic            req, req_wr, ack = 1'b0, done = 1'b0;
  logic [A-1:0]    req_addr;
  logic [L-1:0]    req_len;
  logic [1:0]      req_port;

  int rd_start[NR], rd_max[NR], rd_len[NR], rd_used[NR];
  int wr_start[NW], wr_max[NW], wr_len[NW], wr_used[NW];
  bit rd_ld[NR], wr_ld[NW];
  int m_rd[NR], m_wr[NW], rd_rr, wr_rr;
  int n_chk = 0, n_ok = 0;
  int exp1[5] = '{0, 8, 16, 24, 0};

  always #5 clk = ~clk;

  for (genvar g = 0; g < NR; g++) begin : g_rdp
    assign rd_start_f[g*A +: A] = A'(rd_start[g]);
    assign rd_max_f[g*A +: A]   = A'(rd_max[g]);
    assign rd_len_f[g*L +: L]   = L'(rd_len[g]);
    assign rd_used_f[g*U +: U]  = U'(rd_used[g]);
    assign rd_load_f[g]         = rd_ld[g];
  end
  for (genvar g = 0; g < NW; g++) begin : g_wrp
    assign wr_start_f[g*A +: A] = A'(wr_start[g]);
    assign wr_max_f[g*A +: A]   = A'(wr_max[g]);
    assign wr_len_f[g*L +: L]   = L'(wr_len[g]);
    assign wr_used_f[g*U +: U]  = U'(wr_used[g]);
    assign wr_load_f[g]         = wr_ld[g];
  end

  sdram_port_scheduler #(.NUM_WR(NW), .NUM_RD(NR), .ASIZE(A), .LSIZE(L), .USIZE(U), .RD_FIRST(1)) dut (
    .CLK(clk), .RESET(rst),
    .WR_START(wr_start_f), .WR_MAX(wr_max_f), .WR_LEN(wr_len_f), .WR_LOAD(wr_load_f), .WR_USED(wr_used_f),
    .RD_START(rd_start_f), .RD_MAX(rd_max_f), .RD_LEN(rd_len_f), .RD_LOAD(rd_load_f), .RD_USED(rd_used_f),
    .REQ(req), .REQ_WR(req_wr), .REQ_ADDR(req_addr), .REQ_LEN(req_len), .REQ_PORT(req_port),
    .ACK(ack), .DONE(done), .WR_MASK(wr_mask), .RD_MASK(rd_mask));

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs == exp) n_ok++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit rd_ok(input int i);
    return rd_used[i] < rd_len[i] && rd_len[i] != 0 && !rd_ld[i];
  endfunction
  function automatic bit wr_ok(input int i);
    return wr_used[i] >= wr_len[i] && wr_len[i] != 0 && !wr_ld[i];
  endfunction
  function automatic int wrapped(input int p, input int s, input int m, input int l);
    return (p < m - l) ? p + l : s;
  endfunction

  task automatic model_reset();
    rd_rr = 0;
    wr_rr = 0;
    for (int i = 0; i < NR; i++) m_rd[i] = rd_start[i];
    for (int i = 0; i < NW; i++) m_wr[i] = wr_start[i];
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    chk("rst_req", req, 0);
    chk("rst_fields", {req_wr, req_addr, req_len, req_port, wr_mask, rd_mask}, 0);
    rst = 1'b0;
    model_reset();
  endtask

  // One burst end to end: predict grant, wait for REQ, check fields, ACK/DONE, advance the model.
  task automatic run_burst(input bit same, input int ld_rd, input int ld_start,
                           output int lat, output int got_addr, output int got_port, output int got_wr);
    bit any = 0, is_wr = 0, sup = 0;
    int port = 0, n = 0, exp_addr, exp_len;
    lat = 0; got_addr = -1; got_port = -1; got_wr = -1;
    for (int k = 0; k < NR; k++)
      if (!any && rd_ok((rd_rr + k) % NR)) begin any = 1; is_wr = 0; port = (rd_rr + k) % NR; end
    for (int k = 0; k < NW; k++)
      if (!any && wr_ok((wr_rr + k) % NW)) begin any = 1; is_wr = 1; port = (wr_rr + k) % NW; end
    if (!any) begin
      repeat (4) begin
        ack  = 1'($urandom % 2);
        done = 1'($urandom % 2);
        step();
        chk("no_req", req, 0);
      end
      ack = 0; done = 0;
      return;
    end
    while (!req && n < 12) begin step(); n++; end
    lat = n;
    if (!req) begin chk("req_timeout", 0, 1); return; end
    exp_addr = is_wr ? m_wr[port] : m_rd[port];
    exp_len  = is_wr ? wr_len[port] : rd_len[port];
    chk("req_wr", req_wr, is_wr);
    chk("req_port", req_port, port);
    chk("req_addr", req_addr, exp_addr);
    chk("req_len", req_len, exp_len);
    chk("wr_mask", wr_mask, is_wr ? (1 << port) : 0);
    chk("rd_mask", rd_mask, is_wr ? 0 : (1 << port));
    got_addr = int'(req_addr); got_port = int'(req_port); got_wr = int'(req_wr);
    if (is_wr) wr_rr = (port + 1) % NW; else rd_rr = (port + 1) % NR;
    repeat ($urandom_range(0, 2)) begin
      step();
      chk("req_hold", {req, req_addr}, {1'b1, A'(exp_addr)});
    end
    ack = 1; done = same;
    step();
    ack = 0; done = 0;
    chk("req_drop", req, 0);
    if (!same) begin
      repeat ($urandom_range(1, 3)) begin
        chk("mask_busy", is_wr ? wr_mask : rd_mask, 1 << port);
        step();
      end
      if (ld_rd >= 0) begin
        rd_start[ld_rd] = ld_start;
        rd_ld[ld_rd] = 1;
        step();
        rd_ld[ld_rd] = 0;
        m_rd[ld_rd] = ld_start;
        if (!is_wr && port == ld_rd) sup = 1;
      end
      done = 1;
      step();
      done = 0;
    end
    chk("mask_clear", {wr_mask, rd_mask}, 0);
    if (!sup) begin
      if (is_wr) m_wr[port] = wrapped(m_wr[port], wr_start[port], wr_max[port], wr_len[port]);
      else       m_rd[port] = wrapped(m_rd[port], rd_start[port], rd_max[port], rd_len[port]);
    end
  endtask

  task automatic cfg_clear();
    for (int i = 0; i < NR; i++) begin rd_start[i] = 0; rd_max[i] = 64; rd_len[i] = 0; rd_used[i] = 0; end
    for (int i = 0; i < NW; i++) begin wr_start[i] = 0; wr_max[i] = 64; wr_len[i] = 0; wr_used[i] = 0; end
  endtask

  initial begin
    int lat, ga, gp, gw, n;
    cfg_clear();
    step();

    // single read port wrapping at MAX
    rd_len[0] = 8; rd_max[0] = 32;
    do_reset();
    for (int b = 0; b < 5; b++) begin
      run_burst(0, -1, 0, lat, ga, gp, gw);
      chk("t1_addr", ga, exp1[b]);
    end

    // two eligible reads alternate
    cfg_clear();
    rd_len[0] = 4; rd_len[1] = 4; rd_start[1] = 200; rd_max[1] = 300;
    do_reset();
    for (int b = 0; b < 4; b++) begin
      run_burst(0, -1, 0, lat, ga, gp, gw);
      chk("t2_port", gp, b % 2);
    end

    // reads beat an eligible write
    cfg_clear();
    rd_len[1] = 4; wr_len[0] = 8; wr_used[0] = 16; wr_start[0] = 500; wr_max[0] = 600;
    do_reset();
    run_burst(0, -1, 0, lat, ga, gp, gw);
    chk("t3_read_first", {gw[0], gp[1:0]}, {1'b0, 2'd1});
    rd_used[1] = 100;
    run_burst(0, -1, 0, lat, ga, gp, gw);
    chk("t3_write_next", {gw[0], gp[1:0], ga}, {1'b1, 2'd0, 32'd500});

    // reload while in flight wins over the UPDATE increment
    cfg_clear();
    rd_len[0] = 8; rd_max[0] = 32;
    do_reset();
    run_burst(0, -1, 0, lat, ga, gp, gw);
    run_burst(0, -1, 0, lat, ga, gp, gw);
    run_burst(0, 0, 100, lat, ga, gp, gw);
    chk("t4_inflight_addr", ga, 16);
    run_burst(0, -1, 0, lat, ga, gp, gw);
    chk("t4_reload_addr", ga, 100);

    // ACK and DONE together, then the 2-cycle gap
    run_burst(1, -1, 0, lat, ga, gp, gw);
    run_burst(0, -1, 0, lat, ga, gp, gw);
    chk("t5_gap", lat, 2);

    // reset while busy clears outputs immediately
    n = 0;
    while (!req && n < 12) begin step(); n++; end
    chk("t6_req_seen", req, 1);
    ack = 1;
    step();
    ack = 0;
    chk("t6_busy_mask", rd_mask, 1);
    #1 rst = 1;
    #1 chk("t6_async_clear", {req, req_wr, req_addr, req_len, req_port, wr_mask, rd_mask}, 0);
    step();
    rst = 0;
    model_reset();
    run_burst(0, -1, 0, lat, ga, gp, gw);
    chk("t6_addr_start", ga, 100);

    // randomized phases
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < NR; i++) begin
        rd_start[i] = $urandom_range(0, 1000);
        rd_len[i]   = ($urandom % 8 == 0) ? 0 : $urandom_range(1, 16);
        rd_max[i]   = rd_start[i] + rd_len[i] * $urandom_range(1, 5) + $urandom_range(0, 3);
      end
      for (int i = 0; i < NW; i++) begin
        wr_start[i] = $urandom_range(0, 1000);
        wr_len[i]   = ($urandom % 8 == 0) ? 0 : $urandom_range(1, 16);
        wr_max[i]   = wr_start[i] + wr_len[i] * $urandom_range(1, 5) + $urandom_range(0, 3);
      end
      do_reset();
      for (int b = 0; b < 25; b++) begin
        for (int i = 0; i < NR; i++) rd_used[i] = $urandom_range(0, 20);
        for (int i = 0; i < NW; i++) wr_used[i] = $urandom_range(0, 24);
        run_burst(1'($urandom % 2), ($urandom % 4 == 0) ? int'($urandom % NR) : -1,
                  $urandom_range(0, 1000), lat, ga, gp, gw);
      end
    end

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end
endmodule
